// File: rtl/drac_icache_pkg.sv
// Shared constants and types for the icache refill path.
// The optional ICACHE_IFILL_PERF_EN build uses IFILL_PERF_W for its counters.
package drac_icache_pkg;

    localparam int ICACHE_PADDR_W = 40;
    localparam int ICACHE_LINE_W  = 256;
    localparam int IFILL_BEAT_W   = 64;
    localparam int IFILL_NBEATS   = ICACHE_LINE_W / IFILL_BEAT_W;
    localparam int IFILL_PERF_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DRAIN,
        RESP
    } ifill_state_t;

endpackage

// File: rtl/icache_ifill_if.sv
// Refill unit bus: controller-side fill request/response plus the L2 read channel.
// slave is the refill unit's view, master is the environment's (controller + L2).
interface icache_ifill_if
    import drac_icache_pkg::*;
#(
    parameter int PADDR_W = ICACHE_PADDR_W,
    parameter int LINE_W  = ICACHE_LINE_W,
    parameter int BEAT_W  = IFILL_BEAT_W
) ();

    logic               ifill_req_valid_i;
    logic [PADDR_W-1:0] ifill_req_paddr_i;
    logic               ifill_kill_i;
    logic               ifill_sent_ack_o;
    logic               ifill_resp_valid_o;
    logic               valid_ifill_resp_o;
    logic [LINE_W-1:0]  ifill_resp_data_o;
    logic               ifill_resp_err_o;
    logic               l2_req_valid_o;
    logic               l2_req_ready_i;
    logic [PADDR_W-1:0] l2_req_paddr_o;
    logic               l2_beat_valid_i;
    logic [BEAT_W-1:0]  l2_beat_data_i;
    logic               l2_beat_err_i;

    modport slave (
        input  ifill_req_valid_i, ifill_req_paddr_i, ifill_kill_i,
        input  l2_req_ready_i, l2_beat_valid_i, l2_beat_data_i, l2_beat_err_i,
        output ifill_sent_ack_o, ifill_resp_valid_o, valid_ifill_resp_o,
        output ifill_resp_data_o, ifill_resp_err_o, l2_req_valid_o, l2_req_paddr_o
    );

    modport master (
        output ifill_req_valid_i, ifill_req_paddr_i, ifill_kill_i,
        output l2_req_ready_i, l2_beat_valid_i, l2_beat_data_i, l2_beat_err_i,
        input  ifill_sent_ack_o, ifill_resp_valid_o, valid_ifill_resp_o,
        input  ifill_resp_data_o, ifill_resp_err_o, l2_req_valid_o, l2_req_paddr_o
    );

endinterface

// File: rtl/icache_ifill_linebuf.sv
// Beat counter and line assembly buffer for the refill unit.
// The buffer is not cleared between fills so the last line stays visible until overwritten.
module icache_ifill_linebuf
    import drac_icache_pkg::*;
#(
    parameter int LINE_W = ICACHE_LINE_W,
    parameter int BEAT_W = IFILL_BEAT_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clear_i,
    input  logic              cnt_en_i,
    input  logic              wr_en_i,
    input  logic [BEAT_W-1:0] beat_data_i,
    input  logic              beat_err_i,
    output logic              last_beat_o,
    output logic [LINE_W-1:0] line_o,
    output logic              err_o
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              err_q, err_d;

    assign last_beat_o = (beatCnt_q == CNT_W'(NBEATS - 1));
    assign line_o      = line_q;
    assign err_o       = err_q;

    // Drained beats are counted but never written, so wr_en_i only matters with cnt_en_i.
    always_comb begin
        beatCnt_d = beatCnt_q;
        line_d    = line_q;
        err_d     = err_q;
        if (clear_i) begin
            beatCnt_d = '0;
            err_d     = 1'b0;
        end else if (cnt_en_i) begin
            beatCnt_d = last_beat_o ? '0 : beatCnt_q + 1'b1;
            if (wr_en_i) begin
                line_d[int'(beatCnt_q)*BEAT_W +: BEAT_W] = beat_data_i;
                err_d = err_q | beat_err_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beatCnt_q <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            beatCnt_q <= beatCnt_d;
            line_q    <= line_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/icache_ifill.sv
// Instruction-cache refill unit: one outstanding line fill from L2, assembled beat by beat.
// Define ICACHE_IFILL_PERF_EN to add saturating fill/kill event counters.
module icache_ifill
    import drac_icache_pkg::*;
#(
    parameter int PADDR_W = ICACHE_PADDR_W,
    parameter int LINE_W  = ICACHE_LINE_W,
    parameter int BEAT_W  = IFILL_BEAT_W
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    icache_ifill_if.slave           bus
`ifdef ICACHE_IFILL_PERF_EN
    ,
    output logic [IFILL_PERF_W-1:0] perf_fill_cnt_o,
    output logic [IFILL_PERF_W-1:0] perf_kill_cnt_o
`endif
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [PADDR_W-1:0] ALIGN_MASK = {{(PADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    ifill_state_t       state_q, state_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic               clearBuf, cntEn, wrEn, lastBeat, bufErr;
    logic [LINE_W-1:0]  lineBuf;

    icache_ifill_linebuf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_linebuf (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (clearBuf),
        .cnt_en_i    (cntEn),
        .wr_en_i     (wrEn),
        .beat_data_i (bus.l2_beat_data_i),
        .beat_err_i  (bus.l2_beat_err_i),
        .last_beat_o (lastBeat),
        .line_o      (lineBuf),
        .err_o       (bufErr)
    );

    // Once L2 has taken the request every beat must be absorbed, hence DRAIN after a late kill.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        clearBuf = 1'b0;
        cntEn    = 1'b0;
        wrEn     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ifill_req_valid_i && !bus.ifill_kill_i) begin
                    addr_d   = bus.ifill_req_paddr_i & ALIGN_MASK;
                    clearBuf = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.ifill_kill_i) begin
                    state_d = bus.l2_req_ready_i ? DRAIN : IDLE;
                end else if (bus.l2_req_ready_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.l2_beat_valid_i) begin
                    cntEn = 1'b1;
                    wrEn  = 1'b1;
                end
                if (bus.l2_beat_valid_i && lastBeat) begin
                    state_d = bus.ifill_kill_i ? IDLE : RESP;
                end else if (bus.ifill_kill_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.l2_beat_valid_i) begin
                    cntEn = 1'b1;
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.l2_req_valid_o     = (state_q == REQ);
    assign bus.l2_req_paddr_o     = addr_q;
    assign bus.ifill_sent_ack_o   = (state_q == FILL) || (state_q == DRAIN);
    assign bus.ifill_resp_valid_o = (state_q == RESP);
    assign bus.valid_ifill_resp_o = (state_q == RESP) && !bus.ifill_kill_i;
    assign bus.ifill_resp_err_o   = (state_q == RESP) && bufErr;
    assign bus.ifill_resp_data_o  = lineBuf;

`ifdef ICACHE_IFILL_PERF_EN
    logic [IFILL_PERF_W-1:0] perfFill_q, perfKill_q;
    logic                    fillEvt, killEvt;

    assign fillEvt = (state_q == RESP) && !bus.ifill_kill_i;
    assign killEvt = ((state_q == REQ) && bus.ifill_kill_i) ||
                     ((state_q == FILL) && (state_d == DRAIN));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perfFill_q <= '0;
            perfKill_q <= '0;
        end else begin
            if (fillEvt && (perfFill_q != '1)) perfFill_q <= perfFill_q + 1'b1;
            if (killEvt && (perfKill_q != '1)) perfKill_q <= perfKill_q + 1'b1;
        end
    end

    assign perf_fill_cnt_o = perfFill_q;
    assign perf_kill_cnt_o = perfKill_q;
`endif

endmodule

// File: tb/tb_icache_ifill.sv
// Directed and randomized bench for icache_ifill against a transaction-level line model.
// Build with ICACHE_IFILL_PERF_EN to also check the event counters.
module tb_icache_ifill;
    import drac_icache_pkg::*;

    localparam int PW = ICACHE_PADDR_W;
    localparam int LW = ICACHE_LINE_W;
    localparam int BW = IFILL_BEAT_W;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            expFills = 0;
    int            expKills = 0;
    logic [LW-1:0] expLine = '0;

    icache_ifill_if #(.PADDR_W(PW), .LINE_W(LW), .BEAT_W(BW)) bus ();

`ifdef ICACHE_IFILL_PERF_EN
    logic [31:0] perfFill, perfKill;
`endif

    icache_ifill #(.PADDR_W(PW), .LINE_W(LW), .BEAT_W(BW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
`ifdef ICACHE_IFILL_PERF_EN
        ,
        .perf_fill_cnt_o (perfFill),
        .perf_kill_cnt_o (perfKill)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic reqV, input logic [PW-1:0] paddr, input logic kill,
                                 input logic ready, input logic beatV, input logic [BW-1:0] data,
                                 input logic berr);
        bus.ifill_req_valid_i = reqV;
        bus.ifill_req_paddr_i = paddr;
        bus.ifill_kill_i      = kill;
        bus.l2_req_ready_i    = ready;
        bus.l2_beat_valid_i   = beatV;
        bus.l2_beat_data_i    = data;
        bus.l2_beat_err_i     = berr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic reqV, input logic ack, input logic respV);
        checkOutput({tag, ".l2_req_valid"}, LW'(bus.l2_req_valid_o), LW'(reqV));
        checkOutput({tag, ".sent_ack"}, LW'(bus.ifill_sent_ack_o), LW'(ack));
        checkOutput({tag, ".resp_valid"}, LW'(bus.ifill_resp_valid_o), LW'(respV));
    endtask

    function automatic logic [LW-1:0] randLine();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One complete fill; the model expects the whole line back one cycle after the last beat.
    task automatic runFill(input string tag, input logic [PW-1:0] paddr, input logic [LW-1:0] line,
                           input int readyDly, input int gap, input logic [NB-1:0] errMask,
                           input bit killInResp);
        logic [PW-1:0] aligned;
        aligned = paddr - (paddr % PW'(LW / 8));
        applyStimulus(1'b1, paddr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        for (int d = 0; d < readyDly; d++) begin
            checkCtl({tag, ".wait"}, 1'b1, 1'b0, 1'b0);
            checkOutput({tag, ".wait.paddr"}, LW'(bus.l2_req_paddr_o), LW'(aligned));
            applyStimulus(1'b1, PW'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        checkCtl({tag, ".req"}, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, ".paddr"}, LW'(bus.l2_req_paddr_o), LW'(aligned));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++) begin
                checkCtl({tag, ".gap"}, 1'b0, 1'b1, 1'b0);
                idle();
                tick();
            end
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, line[b*BW +: BW], errMask[b]);
            tick();
            if (b < NB - 1) checkCtl({tag, ".beat"}, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, killInResp, 1'b0, 1'b0, '0, 1'b0);
        #1;
        expLine = line;
        checkCtl({tag, ".resp"}, 1'b0, 1'b0, 1'b1);
        checkOutput({tag, ".valid_resp"}, LW'(bus.valid_ifill_resp_o), LW'(!killInResp));
        checkOutput({tag, ".err"}, LW'(bus.ifill_resp_err_o), LW'(|errMask));
        checkOutput({tag, ".data"}, bus.ifill_resp_data_o, expLine);
        if (!killInResp) expFills++;
        tick();
        idle();
        checkCtl({tag, ".done"}, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".hold"}, bus.ifill_resp_data_o, expLine);
    endtask

    task automatic checkAllZero(input string tag);
        checkCtl(tag, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".valid_resp"}, LW'(bus.valid_ifill_resp_o), '0);
        checkOutput({tag, ".err"}, LW'(bus.ifill_resp_err_o), '0);
        checkOutput({tag, ".data"}, bus.ifill_resp_data_o, '0);
        checkOutput({tag, ".paddr"}, LW'(bus.l2_req_paddr_o), '0);
    endtask

    initial begin
        logic [BW-1:0] beat;
        idle();

        // Reset state
        #12;
        checkAllZero("reset");
        rstn = 1'b1;
        tick();

        // Basic fill
        runFill("basic", 40'h80001234, {64'hD, 64'hC, 64'hB, 64'hA}, 0, 0, '0, 1'b0);
        checkOutput("basic.line", bus.ifill_resp_data_o, {64'hD, 64'hC, 64'hB, 64'hA});

        // Kill while waiting for L2 ready
        applyStimulus(1'b1, 40'h12_3456_7890, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        checkCtl("killReq.c1", 1'b1, 1'b0, 1'b0);
        idle();
        tick();
        checkCtl("killReq.c2", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        expKills++;
        idle();
        for (int i = 0; i < 3; i++) begin
            checkCtl("killReq.idle", 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("killReq.data", bus.ifill_resp_data_o, expLine);

        // Kill after one beat: drain remaining beats
        applyStimulus(1'b1, 40'h00_4000_0040, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        beat = {$urandom, $urandom};
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, beat, 1'b0);
        tick();
        expLine[0 +: BW] = beat;
        checkCtl("killFill.beat0", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick();
        expKills++;
        checkCtl("killFill.drain", 1'b0, 1'b1, 1'b0);
        for (int b = 1; b < NB; b++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
            tick();
            checkCtl("killFill.drainBeat", 1'b0, (b < NB - 1), 1'b0);
        end
        idle();
        checkOutput("killFill.data", bus.ifill_resp_data_o, expLine);
        runFill("afterKill", 40'h00_4000_0080, randLine(), 1, 0, '0, 1'b0);

        // Kill and ready in the same cycle
        applyStimulus(1'b1, 40'h00_5000_0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        expKills++;
        idle();
        checkCtl("killReady.drain", 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < NB; b++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
            tick();
            checkCtl("killReady.beat", 1'b0, (b < NB - 1), 1'b0);
        end
        idle();
        checkOutput("killReady.data", bus.ifill_resp_data_o, expLine);

        // Gapped beats with an error, then a clean fill
        runFill("gapErr", 40'h00_8000_1000, randLine(), 0, 2, 4'b0010, 1'b0);
        runFill("clean", 40'h00_8000_1020, randLine(), 0, 0, '0, 1'b0);

        // Asynchronous reset in the middle of a fill
        applyStimulus(1'b1, 40'h00_9000_0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
        tick();
        idle();
        #2;
        rstn = 1'b0;
        #1;
        expLine = '0;
        expFills = 0;
        expKills = 0;
        checkAllZero("asyncReset");
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
            tick();
            checkAllZero("strayBeat");
        end
        idle();
        runFill("postReset", 40'h00_9000_0040, randLine(), 0, 1, '0, 1'b0);

        // Randomized fills, with occasional stray beats while idle
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
                tick();
                idle();
                checkCtl("rand.stray", 1'b0, 1'b0, 1'b0);
                checkOutput("rand.stray.data", bus.ifill_resp_data_o, expLine);
            end
            runFill("rand", PW'({$urandom, $urandom}), randLine(), $urandom_range(0, 3),
                    $urandom_range(0, 2), NB'($urandom), ($urandom_range(0, 3) == 0));
        end

`ifdef ICACHE_IFILL_PERF_EN
        checkOutput("perf.fill", LW'(perfFill), LW'(expFills));
        checkOutput("perf.kill", LW'(perfKill), LW'(expKills));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
